// File: rtl/piso_pkg.sv
// Shared types and frame-length derivation for the PISO serializer.
// PISO_PARITY_EN appends one even-parity bit to every frame.
package piso_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

`ifdef PISO_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    function automatic int frame_len(input int width);
        return width + PAR_BITS;
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Up-counter with sync clear/load, enable and terminal-count flag.
// Used to track the bit position within a serial frame.
module piso_bit_counter #(
    parameter int CW   = 3,
    parameter int TERM = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load,
    input  logic [CW-1:0] din,
    input  logic          en,
    output logic          tc
);

    localparam logic [CW-1:0] TC_VAL = CW'(TERM);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= din;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    assign tc = (count == TC_VAL);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter, MSB first, valid/ready input.
// Optional even parity bit per frame under PISO_PARITY_EN.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pi_data,
    input  logic             pi_valid,
    output logic             pi_ready,
    output logic             so,
    output logic             so_valid,
    output logic             so_last
);

    localparam int FL = frame_len(WIDTH);
    localparam int CW = $clog2(FL + 1);

    state_t        state;
    logic [FL-1:0] sreg;
    logic [FL-1:0] frame;
    logic          tc;
    logic          accept;
    logic          done;
    logic          busy;

    assign busy     = (state == ST_SHIFT);
    assign so_last  = busy && tc;
    assign pi_ready = (state == ST_IDLE) || so_last;
    assign accept   = pi_valid && pi_ready;
    assign done     = so_last && !accept;

`ifdef PISO_PARITY_EN
    assign frame = {pi_data, ^pi_data};
`else
    assign frame = pi_data;
`endif

    piso_bit_counter #(
        .CW   (CW),
        .TERM (FL - 1)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (done),
        .load (accept),
        .din  ('0),
        .en   (busy && !tc),
        .tc   (tc)
    );

    // so holds the bit on the wire; sreg holds the bits still to go.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            sreg     <= '0;
            so       <= 1'b0;
            so_valid <= 1'b0;
        end else if (accept) begin
            state    <= ST_SHIFT;
            so       <= frame[FL-1];
            sreg     <= {frame[FL-2:0], 1'b0};
            so_valid <= 1'b1;
        end else if (done) begin
            state    <= ST_IDLE;
            so       <= 1'b0;
            sreg     <= '0;
            so_valid <= 1'b0;
        end else if (busy) begin
            so   <= sreg[FL-1];
            sreg <= {sreg[FL-2:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: frame-level reference model,
// directed scenarios, random traffic and a serial-in loopback register.
module tb_piso_serializer;

    localparam int W = 5;
`ifdef PISO_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    typedef struct {
        logic b;
        logic last;
        logic par;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] pi_data;
    logic         pi_valid;
    logic         pi_ready;
    logic         so;
    logic         so_valid;
    logic         so_last;

    int checks   = 0;
    int failures = 0;

    exp_t         expq[$];
    logic [W-1:0] wq[$];
    int           rem   = 0;
    int           nbits = 0;
    logic [W-1:0] lb    = '0;
    bit           mon_en = 1'b0;

    piso_serializer #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .pi_data  (pi_data),
        .pi_valid (pi_valid),
        .pi_ready (pi_ready),
        .so       (so),
        .so_valid (so_valid),
        .so_last  (so_last)
    );

    always #5 clk = ~clk;

    // Reference model: a frame is the word MSB first (plus parity);
    // ready whenever nothing or only the final bit is left to show.
    always @(posedge clk) begin
        if (rst !== 1'b1) begin
            rem = 0;
            expq.delete();
            wq.delete();
            nbits = 0;
        end else if (pi_valid === 1'b1 && rem <= 1) begin
            for (int i = W - 1; i >= 0; i--) begin
                expq.push_back('{b: pi_data[i], last: (FL == W) && (i == 0), par: 1'b0});
            end
`ifdef PISO_PARITY_EN
            expq.push_back('{b: ^pi_data, last: 1'b1, par: 1'b1});
`endif
            wq.push_back(pi_data);
            rem = FL;
        end else if (rem > 0) begin
            rem = rem - 1;
        end
    end

    // Monitor: pops one expected bit per so_valid cycle.
    always @(negedge clk) begin
        exp_t e;
        logic [W-1:0] w;
        if (mon_en) begin
            checks++;
            if (pi_ready !== (rem <= 1)) begin
                failures++;
                $display("FAIL ready: got %b want %b", pi_ready, rem <= 1);
            end
            checks++;
            if (so_valid !== (rem > 0)) begin
                failures++;
                $display("FAIL so_valid: got %b want %b", so_valid, rem > 0);
            end
            if (so_valid === 1'b1) begin
                checks++;
                if (expq.size() == 0) begin
                    failures++;
                    $display("FAIL extra_bit: got so=%b want no frame bit", so);
                end else begin
                    e = expq.pop_front();
                    if (so !== e.b || so_last !== e.last) begin
                        failures++;
                        $display("FAIL bit: got so=%b last=%b want so=%b last=%b",
                                 so, so_last, e.b, e.last);
                    end
                    if (!e.par) begin
                        lb = {lb[W-2:0], so};
                        nbits++;
                        if (nbits == W) begin
                            nbits = 0;
                            w = wq.pop_front();
                            checks++;
                            if (lb !== w) begin
                                failures++;
                                $display("FAIL loopback: got %b want %b", lb, w);
                            end
                        end
                    end
                end
            end else begin
                checks++;
                if (so !== 1'b0 || so_last !== 1'b0) begin
                    failures++;
                    $display("FAIL idle_out: got so=%b last=%b want 0 0", so, so_last);
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] d);
        logic r;
        bit   ok;
        ok       = 1'b0;
        pi_valid = 1'b1;
        pi_data  = d;
        for (int n = 0; n < 64; n++) begin
            r = pi_ready;
            @(negedge clk);
            if (r === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL accept_timeout: got no accept want accept of %b", d);
        end
        pi_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        pi_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] val_a;
        logic [W-1:0] val_b;
        val_a = 5'b10110;
        val_b = 5'b01001;
        rst      = 1'b0;
        pi_valid = 1'b1;
        pi_data  = 5'b11111;
        @(negedge clk);
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle(2);

        send(val_a);
        idle(FL + 2);

        send(val_a);
        send(val_b);
        idle(2 * FL);

        send(val_a);
        pi_valid = 1'b1;
        pi_data  = 5'b11111;
        @(negedge clk);
        send(5'b11111);
        idle(FL + 2);

        send(val_a);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idle(FL + 2);

        for (int i = 0; i < 400; i++) begin
            pi_valid = ($urandom_range(0, 3) != 0);
            pi_data  = W'($urandom);
            if ($urandom_range(0, 150) == 0) rst = 1'b0;
            @(negedge clk);
            rst = 1'b1;
        end
        idle(FL + 4);

        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending bits want 0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter for the serial bit stream consumed by the team's 5-bit serial-in shift register.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB first, one bit per clock.
- After WIDTH shifts, a serial-in register clocked on so_valid holds the original word in bit order.
- Sits between a parallel producer (register file or FIFO) and the serial link.

Parameters:
- WIDTH, 5, data word width in bits; legal range 2 to 32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-low: asserted when rst==0 at the rising edge of clk.
- pi_data  input  WIDTH  parallel word to transmit.
- pi_valid  input  1  producer has a word on pi_data.
- pi_ready  output  1  block can accept a word this cycle.
- so  output  1  serial data bit, MSB first.
- so_valid  output  1  so carries a frame bit this cycle.
- so_last  output  1  final bit of the current frame.

Behaviour:
- Reset (rst==0 at a posedge): state=IDLE; shift register=0; bit counter=0; so=0; so_valid=0; so_last=0; pi_ready=1 from the first cycle after reset. Reset takes priority over every other event.
- States:
  - IDLE: so_valid=0, pi_ready=1.
  - SHIFT: transmitting a frame.
- Accept: a word is accepted when pi_valid && pi_ready at the posedge. pi_data is sampled only on an accept and ignored at all other times.
- pi_ready is combinational: (state==IDLE) || (state==SHIFT && so_last). It never depends on pi_valid.
- Latency: on the accept edge N, the block moves to SHIFT and the first bit, pi_data[WIDTH-1], is registered onto so with so_valid=1. This bit is visible in the cycle after edge N.
- Shifting: each subsequent edge in SHIFT presents the next lower bit. The frame is exactly FRAME_LEN cycles of so_valid=1 (FRAME_LEN=WIDTH, or WIDTH+1 with the optional feature).
- Counter: counts 0..FRAME_LEN-1. so_last=1 when counter==FRAME_LEN-1, otherwise 0.
- End of frame, on the edge where so_last=1:
  - If an accept occurs on that edge, load the new word, reset the counter to 0 and stay in SHIFT. There are zero idle cycles between frames.
  - Otherwise go to IDLE, drive so to 0 and deassert so_valid.
- Idle and invalid outputs: so=0 whenever so_valid=0.
- pi_valid held high while busy has no effect. The producer must hold pi_data stable until pi_ready.
- Reset mid-frame aborts the frame immediately. No partial bits are emitted after reset, and the word is lost.
- Counter width is $clog2(FRAME_LEN+1). No arithmetic overflow is possible. The counter never wraps without an end-of-frame decision.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - The frame is WIDTH data bits followed by one even-parity bit, equal to the XOR-reduce of the accepted word, captured at accept.
  - so_last is asserted on the parity bit.
  - pi_ready during SHIFT is asserted only on the parity cycle.
- Undefined: no parity hardware is built, FRAME_LEN=WIDTH, and the behaviour is exactly as above.

Decomposition:
- Shared package/include (piso_pkg) holds:
  - state encoding constants ST_IDLE=1'b0 and ST_SHIFT=1'b1;
  - the FRAME_LEN derivation (WIDTH plus the parity-bit term under PISO_PARITY_EN).
- One sub-module: piso_bit_counter, a parameterised up-counter with sync clear/load, an enable and a terminal-count flag. The top-level block holds the FSM, shift register and handshake.

Test Plan:
- Reset: hold rst=0 for 3 cycles with pi_valid=1 -> so_valid=0, so=0, so_last=0 throughout; pi_ready=1 on the first cycle after rst=1.
- Single frame: WIDTH=5, pi_data=5'b10110 accepted at edge N -> so=1,0,1,1,0 in cycles N+1..N+5, so_valid=1 for exactly 5 cycles, so_last=1 only in cycle N+5; IDLE from N+6.
- Back-to-back: 5'b10110, then 5'b01001 presented while pi_valid is held -> second accept on the so_last edge; 10 contiguous so_valid cycles carrying 1011001001.
- Busy stall: change pi_data to 5'b11111 mid-frame with pi_valid=1 -> pi_ready=0 until so_last, and the in-flight bits are unchanged.
- Reset mid-frame: rst=0 after 2 bits of 5'b10110 -> so_valid=0 and so=0 in the next cycle, and no further frame bits appear.
- Loopback plus parity: drive a 5-bit serial-in shift register model (clocked when so_valid) with random words -> it holds the sent word after the fifth valid bit. With PISO_PARITY_EN, 5'b10110 appends parity bit 1, and so_last is on the sixth bit.
